// File: rtl/change_dispenser.sv
// Change/refund hopper sequencer: pays out a Q1 amount greedily (1-yuan coins first,
// then 0.5-yuan), one eject at a time, waiting for each drop confirmation.
module change_dispenser #(
   parameter int TIMEOUT_CYC   = 1000,
   parameter int INIT_STOCK_1  = 20,
   parameter int INIT_STOCK_05 = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [5:0] amount,
   input  logic       refill,
   input  logic       drop_1,
   input  logic       drop_05,
   output logic       eject_1,
   output logic       eject_05,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [5:0] remain,
   output logic [7:0] stock_1,
   output logic [7:0] stock_05
);

   localparam int            TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]    S1_INIT  = 8'(INIT_STOCK_1);
   localparam logic [7:0]    S05_INIT = 8'(INIT_STOCK_05);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_EJ1,
      S_EJ05,
      S_WAIT1,
      S_WAIT05
   } state_t;

   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [5:0]    remain_q;
   logic [7:0]    stock_1_q;
   logic [7:0]    stock_05_q;
   logic          eject_1_q;
   logic          eject_05_q;
   logic          busy_q;
   logic          done_q;
   logic          error_q;

   // Outputs are registered alongside the state so every pulse lines up with the
   // state it belongs to (eject in EJx, done/error in the first IDLE cycle).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only, and every
         // register, stock included, gets an explicit reset value.
         state_q    <= S_IDLE;
         timer_q    <= '0;
         remain_q   <= '0;
         stock_1_q  <= S1_INIT;
         stock_05_q <= S05_INIT;
         eject_1_q  <= 1'b0;
         eject_05_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         eject_1_q  <= 1'b0;
         eject_05_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  remain_q <= amount;
                  state_q  <= S_SELECT;
                  busy_q   <= 1'b1;
               end else if (refill) begin
                  stock_1_q  <= S1_INIT;
                  stock_05_q <= S05_INIT;
               end
            end

            S_SELECT: begin
               if (remain_q == 6'd0) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (remain_q >= 6'd2 && stock_1_q != 8'd0) begin
                  state_q   <= S_EJ1;
                  eject_1_q <= 1'b1;
               end else if (stock_05_q != 8'd0) begin
                  state_q    <= S_EJ05;
                  eject_05_q <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
               end
            end

            S_EJ1: begin
               timer_q <= '0;
               state_q <= S_WAIT1;
            end

            S_EJ05: begin
               timer_q <= '0;
               state_q <= S_WAIT05;
            end

            // A drop on the final timer count still counts as a confirmation.
            S_WAIT1: begin
               if (drop_1) begin
                  remain_q  <= remain_q - 6'd2;
                  stock_1_q <= stock_1_q - 8'd1;
                  state_q   <= S_SELECT;
               end else if (timer_q == T_LAST) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            S_WAIT05: begin
               if (drop_05) begin
                  remain_q   <= remain_q - 6'd1;
                  stock_05_q <= stock_05_q - 8'd1;
                  state_q    <= S_SELECT;
               end else if (timer_q == T_LAST) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign eject_1  = eject_1_q;
   assign eject_05 = eject_05_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign remain   = remain_q;
   assign stock_1  = stock_1_q;
   assign stock_05 = stock_05_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a payout model fills a scoreboard of expected
// ejects and final outcomes, which are popped as the DUT ejects and finishes.
module tb_change_dispenser;

   localparam int TOUT  = 8;
   localparam int LIMIT = 400;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [5:0] amount;
   logic       refill;
   logic       drop_1;
   logic       drop_05;
   logic       eject_1;
   logic       eject_05;
   logic       busy;
   logic       done;
   logic       error;
   logic [5:0] remain;
   logic [7:0] stock_1;
   logic [7:0] stock_05;

   typedef struct {
      logic       done;
      logic [5:0] rem;
      logic [7:0] s1;
      logic [7:0] s05;
   } outcome_t;

   int       coin_q[$];
   outcome_t out_q[$];
   int       m_s1;
   int       m_s05;
   int       checks = 0;
   int       errors = 0;

   change_dispenser #(
      .TIMEOUT_CYC  (TOUT),
      .INIT_STOCK_1 (20),
      .INIT_STOCK_05(20)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .amount  (amount),
      .refill  (refill),
      .drop_1  (drop_1),
      .drop_05 (drop_05),
      .eject_1 (eject_1),
      .eject_05(eject_05),
      .busy    (busy),
      .done    (done),
      .error   (error),
      .remain  (remain),
      .stock_1 (stock_1),
      .stock_05(stock_05)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Requests a payout. dly = cycles after the eject cycle at which the hopper
   // answers (0 = never); junk injects ignored inputs in the first WAIT cycle.
   task automatic dispense(input logic [5:0] amt, input int dly, input bit junk);
      int       r, s1, s05, cnt, ej_idx, first_ej;
      bit       err, ok, fin, wait_one, junk_pending;
      outcome_t o;
      outcome_t got;
      int       coin;

      ok  = (dly >= 1) && (dly <= TOUT);
      r   = int'(amt);
      s1  = m_s1;
      s05 = m_s05;
      err = 1'b0;
      while (!err && r != 0) begin
         if (r >= 2 && s1 > 0) begin
            coin_q.push_back(1);
            if (!ok) err = 1'b1;
            else begin s1--; r -= 2; end
         end else if (s05 > 0) begin
            coin_q.push_back(0);
            if (!ok) err = 1'b1;
            else begin s05--; r -= 1; end
         end else begin
            err = 1'b1;
         end
      end
      o.done = !err;
      o.rem  = 6'(r);
      o.s1   = 8'(s1);
      o.s05  = 8'(s05);
      out_q.push_back(o);
      m_s1  = s1;
      m_s05 = s05;

      @(negedge clk);
      start  = 1'b1;
      amount = amt;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);

      cnt          = 0;
      ej_idx       = -1;
      first_ej     = 1;
      fin          = 1'b0;
      wait_one     = 1'b0;
      junk_pending = junk;
      for (int idx = 0; idx < LIMIT && !fin; idx++) begin
         if (idx > 0) @(negedge clk);
         drop_1  = 1'b0;
         drop_05 = 1'b0;
         start   = 1'b0;
         refill  = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               if (wait_one) drop_1 = 1'b1;
               else          drop_05 = 1'b1;
            end
         end
         if (junk_pending && ej_idx >= 0 && idx == ej_idx + 1) begin
            junk_pending = 1'b0;
            if (wait_one) drop_05 = 1'b1;
            else          drop_1 = 1'b1;
            start  = 1'b1;
            amount = 6'd63;
            refill = 1'b1;
         end
         if (eject_1 || eject_05) begin
            check("eject_expected", coin_q.size() > 0, 1);
            check("eject_exclusive", eject_1 & eject_05, 0);
            if (coin_q.size() > 0) begin
               coin = coin_q.pop_front();
               check("eject_hopper", eject_1, coin);
            end
            if (first_ej != 0) check("first_eject_cycle", idx, 1);
            first_ej = 0;
            ej_idx   = idx;
            wait_one = eject_1;
            cnt      = ok ? dly : 0;
         end
         if (done || error) begin
            fin = 1'b1;
            got = out_q.pop_front();
            check("done", done, got.done);
            check("error", error, !got.done);
            check("remain", remain, got.rem);
            check("stock_1", stock_1, got.s1);
            check("stock_05", stock_05, got.s05);
            check("busy_at_end", busy, 0);
            check("ejects_consumed", coin_q.size(), 0);
            if (!ok && ej_idx >= 0) check("timeout_latency", idx - ej_idx, TOUT + 1);
            if (amt == 6'd0) check("zero_done_cycle", idx, 1);
         end
      end
      check("dispense_finished", fin, 1);
      drop_1  = 1'b0;
      drop_05 = 1'b0;
      start   = 1'b0;
      refill  = 1'b0;
      coin_q.delete();
      out_q.delete();
      @(negedge clk);
      check("single_pulse", done | error, 0);
   endtask

   initial begin
      bit seen;
      rst_n   = 1'b0;
      start   = 1'b0;
      amount  = 6'd0;
      refill  = 1'b0;
      drop_1  = 1'b0;
      drop_05 = 1'b0;
      m_s1    = 20;
      m_s05   = 20;

      #12;
      check("rst_busy", busy, 0);
      check("rst_ejects", {eject_1, eject_05}, 0);
      check("rst_done_error", {done, error}, 0);
      check("rst_remain", remain, 0);
      check("rst_stock_1", stock_1, 20);
      check("rst_stock_05", stock_05, 20);
      @(negedge clk);
      rst_n = 1'b1;

      // Greedy payout of 3.5 yuan.
      dispense(6'd7, 2, 1'b0);
      check("greedy_stock", {stock_1, stock_05}, {8'd17, 8'd19});

      // Refill in IDLE.
      @(negedge clk);
      refill = 1'b1;
      @(negedge clk);
      refill = 1'b0;
      check("refill_idle", {stock_1, stock_05}, {8'd20, 8'd20});
      m_s1  = 20;
      m_s05 = 20;

      // Drain to a single 1-yuan coin, then fall back to 0.5-yuan coins.
      dispense(6'd38, 1, 1'b0);
      check("drain_stock", {stock_1, stock_05}, {8'd1, 8'd20});
      dispense(6'd6, 2, 1'b0);
      check("fallback_stock", {stock_1, stock_05}, {8'd0, 8'd16});

      // Leave 0/2, then ask for 2.5 yuan.
      dispense(6'd14, 1, 1'b0);
      dispense(6'd5, 2, 1'b0);
      check("insufficient_remain", remain, 3);
      check("insufficient_stock", {stock_1, stock_05}, {8'd0, 8'd0});

      @(negedge clk);
      refill = 1'b1;
      @(negedge clk);
      refill = 1'b0;
      m_s1  = 20;
      m_s05 = 20;

      // Timeout with no drop, then a drop on the last WAIT cycle.
      dispense(6'd2, 0, 1'b0);
      check("timeout_remain", remain, 2);
      check("timeout_stock_1", stock_1, 20);
      dispense(6'd2, TOUT, 1'b0);

      // Stray start / wrong-hopper drop / refill while busy.
      dispense(6'd2, 3, 1'b1);
      check("ignored_inputs_stock", {stock_1, stock_05}, {8'd18, 8'd20});

      // Zero amount.
      dispense(6'd0, 1, 1'b0);

      // Reset during WAIT1.
      @(negedge clk);
      start  = 1'b1;
      amount = 6'd2;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (eject_1) seen = 1'b1;
         else @(negedge clk);
      end
      check("mid_reset_eject_seen", seen, 1);
      @(negedge clk);
      check("mid_reset_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_reset_busy", busy, 0);
      check("mid_reset_outputs", {eject_1, eject_05, done, error}, 0);
      check("mid_reset_remain", remain, 0);
      check("mid_reset_stock", {stock_1, stock_05}, {8'd20, 8'd20});
      @(negedge clk);
      rst_n = 1'b1;
      m_s1  = 20;
      m_s05 = 20;
      dispense(6'd2, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequences the change/refund hoppers of the vending machine. On a request it pays out an amount in Q1 fixed point (value × 2, i.e. 0.5-yuan units), using 1-yuan coins first and then 0.5-yuan coins. It issues one eject pulse at a time and waits for each hopper's drop-sensor confirmation before continuing. It sits between the purchase FSM, which supplies the charge amount from `coin_sum`, and the two coin hoppers, and it tracks hopper stock.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1000: cycles allowed in WAIT for a drop confirmation.
- `INIT_STOCK_1`, default 20: 1-yuan coin count loaded at reset and on `refill`.
- `INIT_STOCK_05`, default 20: 0.5-yuan coin count loaded at reset and on `refill`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `amount`  in  6  refund value, Q1 (0..63 = 0..31.5 yuan).
- `refill`  in  1  reload both stock counters to their INIT values; honoured only in IDLE.
- `drop_1`  in  1  1-yuan hopper drop sensor, one-cycle pulse.
- `drop_05`  in  1  0.5-yuan hopper drop sensor, one-cycle pulse.
- `eject_1`  out  1  one-cycle eject command to the 1-yuan hopper.
- `eject_05`  out  1  one-cycle eject command to the 0.5-yuan hopper.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse: the full amount has been paid.
- `error`  out  1  one-cycle pulse: insufficient stock or timeout.
- `remain`  out  6  amount still owed (Q1).
- `stock_1`  out  8  1-yuan coins in the hopper.
- `stock_05`  out  8  0.5-yuan coins in the hopper.

## Operation
States: IDLE, SELECT, EJ1, EJ05, WAIT1, WAIT05. Encoding is free.

- **IDLE**
  - `start` latches `amount` into `remain` and moves to SELECT.
  - Otherwise, `refill` loads `stock_1` and `stock_05` from their INIT values.
  - If `start` and `refill` arrive together, `start` wins and `refill` is dropped.
- **SELECT**
  - `remain`==0: go to IDLE and pulse `done`.
  - Else if `remain`>=2 and `stock_1`>0: go to EJ1.
  - Else if `stock_05`>0: go to EJ05.
  - Else: go to IDLE and pulse `error`. `remain` keeps the unpaid value.
- **EJ1 / EJ05**
  - `eject_1` / `eject_05` is high for exactly this one cycle (Moore output).
  - Clear the wait timer and go to WAIT1 / WAIT05.
- **WAIT1**
  - `drop_1`=1: `remain` -= 2, `stock_1` -= 1, go to SELECT.
  - Else if timer == `TIMEOUT_CYC`-1: go to IDLE and pulse `error`. Stock and `remain` are unchanged.
  - Else: timer += 1.
- **WAIT05**: same as WAIT1 with `drop_05`, `remain` -= 1, `stock_05` -= 1.

Rules:
- A drop pulse takes priority over the timeout in the same cycle.
- A drop from the hopper not being waited on is ignored, as are drops outside WAIT.
- `start` is ignored while `busy`; `refill` is ignored while `busy`.
- Stock counters never wrap below 0; SELECT guarantees a counter is >0 before ejecting from it.
- `remain` cannot underflow, because EJ1 is chosen only when `remain`>=2.
- Timer width is `$clog2(TIMEOUT_CYC)`, with a minimum of 1 bit.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=`eject_1`=`eject_05`=`done`=`error`=0.
  - `remain`=0, timer=0.
  - `stock_1`=`INIT_STOCK_1`, `stock_05`=`INIT_STOCK_05`.
- `start` sampled at edge T: `busy`=1 from T+1 (SELECT); the first eject is high in cycle T+2.
- Per coin: SELECT (1 cycle) + EJ (1 cycle) + WAIT (≥1 cycle).
  - A drop arriving in the first WAIT cycle gives 3 cycles per coin.
  - A drop in the cycle right after the eject counts (that cycle is WAIT).
- `done` and `error` are asserted in the first IDLE cycle, with `busy`=0 in that same cycle.
- `amount`=0: `busy` is high for one cycle (T+1); `done` pulses at T+2.
- Timeout: with the eject at cycle E, `error` is reported at E+1+`TIMEOUT_CYC` if no drop arrives.
- `rst_n` low at any time, mid-dispense included:
  - Asynchronously returns to IDLE, drops all outputs to reset values and reloads stock.
  - An in-flight eject is abandoned.

## Test plan
- **Greedy payout**: stock 20/20, `amount`=7, hoppers echo a drop 2 cycles after each eject → EJ1 ×3 then EJ05 ×1; `done` once; `remain`=0; stock 17/19.
- **Stock fallback**: `stock_1`=1, `amount`=6 → 1× `eject_1` then 4× `eject_05`; `done`; stock 0/16.
- **Insufficient stock**: stock 0/2, `amount`=5 → 2× `eject_05` then `error`; `remain`=3; stock 0/0; `busy`=0 in the `error` cycle.
- **Timeout**: `TIMEOUT_CYC`=8, `amount`=2, no `drop_1` → `error` exactly 9 cycles after `eject_1`; `remain`=2; `stock_1` unchanged. Repeat with `drop_1` on the final WAIT cycle → accepted, `done`.
- **Ignored inputs**:
  - `start` pulse mid-dispense → no effect.
  - `drop_05` while in WAIT1 → no effect.
  - `refill` while busy → stock unchanged.
  - `refill` in IDLE → stock 20/20.
  - `amount`=0 → `done` at T+2.
- **Reset mid-operation**: `rst_n` low during WAIT1 → outputs at reset values immediately; stock reloaded; a subsequent `start` with `amount`=2 completes normally.
